// File: rtl/zep_mem_pkg.sv
// -----------------------------------------------------------------------------
// zep_mem_pkg
// Shared types and constants for the unified-memory arbiter.
//   owner_t     : which requester owns the outstanding memory transaction
//   arb_state_t : arbiter FSM states
//   BE_ALL      : full-word byte enable, used for instruction fetches
// -----------------------------------------------------------------------------
package zep_mem_pkg;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } arb_state_t;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage : zep_mem_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port, fixed-latency memory between instruction fetch (i_*)
// and the load/store unit (d_*). One transaction is outstanding at a time. The
// response is routed to its owner as a one-cycle valid pulse. A fetch that is
// hit by i_flush while in flight completes on the memory side but produces no
// i_valid.
//
// Parameters
//   LATENCY : cycles from memory accept (m_req) to m_rdata valid, >= 1
//
// Configuration macro
//   MEM_ARB_RR_EN : defined   -> round-robin on conflict (port != last wins)
//                   undefined -> data port always wins a conflict
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   i_req/i_addr/i_flush              fetch request, address, branch kill
//   i_rdata/i_valid/i_stall           fetch response, completion pulse, stall
//   d_req/d_we/d_addr/d_wdata/d_be    load/store request and command
//   d_rdata/d_valid/d_stall           load data, completion pulse, stall
//   m_req/m_we/m_addr/m_wdata/m_be    memory command, one strobe per access
//   m_rdata                           memory read data, LATENCY after m_req
// -----------------------------------------------------------------------------
module mem_arbiter
    import zep_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_flush,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    output logic        i_stall,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        d_stall,

    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_be,
    input  logic [31:0] m_rdata
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

    arb_state_t       state;
    owner_t           owner;
    logic [CNT_W-1:0] cnt;
    logic             kill;
`ifdef MEM_ARB_RR_EN
    owner_t           last;
`endif

    logic   i_elig;
    logic   grant;
    owner_t winner;
    logic   done;

    // A fetch raised together with a taken branch is already stale.
    assign i_elig = i_req && !i_flush;

    // NOTE: every signal assigned in an always_comb gets a default on entry,
    // otherwise paths that skip the assignment infer a latch.
    always_comb begin
        grant  = 1'b0;
        winner = OWN_I;
        if (!reset && state == S_IDLE) begin
            if (i_elig && d_req) begin
                grant = 1'b1;
`ifdef MEM_ARB_RR_EN
                winner = (last == OWN_I) ? OWN_D : OWN_I;
`else
                winner = OWN_D;
`endif
            end else if (i_elig) begin
                grant  = 1'b1;
                winner = OWN_I;
            end else if (d_req) begin
                grant  = 1'b1;
                winner = OWN_D;
            end
        end
    end

    // Memory command is driven only in the accept cycle; zero otherwise.
    always_comb begin
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        if (grant) begin
            m_req = 1'b1;
            if (winner == OWN_D) begin
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                m_be    = d_be;
            end else begin
                m_addr = i_addr;
                m_be   = BE_ALL;
            end
        end
    end

    // Response cycle. Gating with reset abandons a transaction caught by reset.
    assign done    = !reset && state == S_BUSY && cnt == CNT_LAST;
    assign i_valid = done && owner == OWN_I && !kill && !i_flush;
    assign d_valid = done && owner == OWN_D;

    // Read data is forced to zero outside the valid pulse so an idle or
    // resetting arbiter presents all-zero outputs.
    assign i_rdata = i_valid ? m_rdata : '0;
    assign d_rdata = d_valid ? m_rdata : '0;

    assign i_stall = !reset && i_req && !i_valid;
    assign d_stall = !reset && d_req && !d_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            owner <= OWN_I;
            cnt   <= '0;
            kill  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last  <= OWN_D;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        state <= S_BUSY;
                        owner <= winner;
                        cnt   <= CNT_W'(1);
                        kill  <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        last  <= winner;
`endif
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    // Flush only matters to a fetch; data transactions ignore it.
                    if (owner == OWN_I && i_flush) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. u_dut (LATENCY=2) runs a cycle table
// against a byte-enabled memory model; u_dut3 (LATENCY=3) covers the fetch
// kill case. Hand-written sequences cover conflicts and mid-transaction reset.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- LATENCY = 2 instance ----------------
    logic        i_req, i_flush, i_valid, i_stall;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_valid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    mem_arbiter #(.LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_rdata(m_rdata)
    );

    // Memory model: read-before-write, response two cycles after accept.
    logic [31:0] mem [0:255];
    logic [31:0] rd_pipe0, rd_pipe1;
    assign m_rdata = rd_pipe1;

    always @(posedge clk) begin
        rd_pipe0 <= m_req ? mem[m_addr[9:2]] : 32'h0;
        rd_pipe1 <= rd_pipe0;
        if (m_req && m_we) begin
            for (int b = 0; b < 4; b++) begin
                if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- LATENCY = 3 instance ----------------
    logic        x_i_req, x_i_flush, x_i_valid, x_i_stall;
    logic [31:0] x_i_addr, x_i_rdata;
    logic        x_d_valid, x_d_stall;
    logic [31:0] x_d_rdata;
    logic        x_m_req, x_m_we;
    logic [31:0] x_m_addr, x_m_wdata;
    logic [3:0]  x_m_be;
    logic [31:0] x_m_rdata;
    assign x_m_rdata = 32'hA5A5_A5A5;

    mem_arbiter #(.LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .i_req(x_i_req), .i_addr(x_i_addr), .i_flush(x_i_flush),
        .i_rdata(x_i_rdata), .i_valid(x_i_valid), .i_stall(x_i_stall),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0), .d_be(4'h0),
        .d_rdata(x_d_rdata), .d_valid(x_d_valid), .d_stall(x_d_stall),
        .m_req(x_m_req), .m_we(x_m_we), .m_addr(x_m_addr), .m_wdata(x_m_wdata), .m_be(x_m_be),
        .m_rdata(x_m_rdata)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ctl = {reset, i_req, i_flush, d_req, d_we}
    // flg = {m_req, m_we, i_valid, i_stall, d_valid, d_stall}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic [5:0]  flg;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 19;
    vec_t vec [NV];

    task automatic drive_idle();
        reset = 1'b0; i_req = 1'b0; i_flush = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        drive_idle();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_grant [5];
        bit          found;

        for (int w = 0; w < 256; w++) mem[w] = 32'h0;
        mem[32'h100 >> 2] = 32'h1357_9BDF;
        rd_pipe0 = 32'h0;
        rd_pipe1 = 32'h0;
        drive_idle();
        reset = 1'b1;
        x_i_req = 1'b0; x_i_flush = 1'b0; x_i_addr = 32'h0;
        repeat (3) @(posedge clk);

        //           ctl       i_addr       d_addr       d_wdata       d_be   flg        e_addr       e_wdata       e_be  e_rdata
        vec[0]  = '{5'b10000, 32'h0,       32'h0,       32'h0,        4'h0, 6'b000000, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[1]  = '{5'b00000, 32'h0,       32'h0,       32'h0,        4'h0, 6'b000000, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[2]  = '{5'b01000, 32'h100,     32'h0,       32'h0,        4'h0, 6'b100100, 32'h100,     32'h0,        4'hF, 32'h0};
        vec[3]  = '{5'b01000, 32'h100,     32'h0,       32'h0,        4'h0, 6'b000100, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[4]  = '{5'b01000, 32'h100,     32'h0,       32'h0,        4'h0, 6'b001000, 32'h0,       32'h0,        4'h0, 32'h1357_9BDF};
        vec[5]  = '{5'b00000, 32'h0,       32'h0,       32'h0,        4'h0, 6'b000000, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[6]  = '{5'b00011, 32'h0,       32'h40,      32'hDEAD_BEEF, 4'h3, 6'b110001, 32'h40,      32'hDEAD_BEEF, 4'h3, 32'h0};
        vec[7]  = '{5'b00011, 32'h0,       32'h40,      32'hDEAD_BEEF, 4'h3, 6'b000001, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[8]  = '{5'b00011, 32'h0,       32'h40,      32'hDEAD_BEEF, 4'h3, 6'b000010, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[9]  = '{5'b00010, 32'h0,       32'h40,      32'h0,        4'hF, 6'b100001, 32'h40,      32'h0,        4'hF, 32'h0};
        vec[10] = '{5'b00010, 32'h0,       32'h40,      32'h0,        4'hF, 6'b000001, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[11] = '{5'b00010, 32'h0,       32'h40,      32'h0,        4'hF, 6'b000010, 32'h0,       32'h0,        4'h0, 32'h0000_BEEF};
        vec[12] = '{5'b01110, 32'h100,     32'h40,      32'h0,        4'hF, 6'b100101, 32'h40,      32'h0,        4'hF, 32'h0};
        vec[13] = '{5'b01010, 32'h100,     32'h40,      32'h0,        4'hF, 6'b000101, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[14] = '{5'b01010, 32'h100,     32'h40,      32'h0,        4'hF, 6'b000110, 32'h0,       32'h0,        4'h0, 32'h0000_BEEF};
        vec[15] = '{5'b01000, 32'h100,     32'h0,       32'h0,        4'h0, 6'b100100, 32'h100,     32'h0,        4'hF, 32'h0};
        vec[16] = '{5'b01000, 32'h100,     32'h0,       32'h0,        4'h0, 6'b000100, 32'h0,       32'h0,        4'h0, 32'h0};
        vec[17] = '{5'b01000, 32'h100,     32'h0,       32'h0,        4'h0, 6'b001000, 32'h0,       32'h0,        4'h0, 32'h1357_9BDF};
        vec[18] = '{5'b00000, 32'h0,       32'h0,       32'h0,        4'h0, 6'b000000, 32'h0,       32'h0,        4'h0, 32'h0};

        // ---------------- table-driven cycles ----------------
        for (int k = 0; k < NV; k++) begin
            @(posedge clk); #1;
            {reset, i_req, i_flush, d_req, d_we} = vec[k].ctl;
            i_addr  = vec[k].i_addr;
            d_addr  = vec[k].d_addr;
            d_wdata = vec[k].d_wdata;
            d_be    = vec[k].d_be;
            @(negedge clk);
            check($sformatf("v%0d_m_req",   k), 32'(m_req),   32'(vec[k].flg[5]));
            check($sformatf("v%0d_i_valid", k), 32'(i_valid), 32'(vec[k].flg[3]));
            check($sformatf("v%0d_i_stall", k), 32'(i_stall), 32'(vec[k].flg[2]));
            check($sformatf("v%0d_d_valid", k), 32'(d_valid), 32'(vec[k].flg[1]));
            check($sformatf("v%0d_d_stall", k), 32'(d_stall), 32'(vec[k].flg[0]));
            // Command fields are defined in the accept cycle and in fully idle cycles.
            if (vec[k].flg[5] || vec[k].flg == 6'b000000) begin
                check($sformatf("v%0d_m_we",    k), 32'(m_we),    32'(vec[k].flg[4]));
                check($sformatf("v%0d_m_addr",  k), m_addr,       vec[k].e_addr);
                check($sformatf("v%0d_m_wdata", k), m_wdata,      vec[k].e_wdata);
                check($sformatf("v%0d_m_be",    k), 32'(m_be),    32'(vec[k].e_be));
            end
            if (vec[k].flg[3])
                check($sformatf("v%0d_i_rdata", k), i_rdata, vec[k].e_rdata);
            if (vec[k].flg[1] && !vec[k].ctl[0])
                check($sformatf("v%0d_d_rdata", k), d_rdata, vec[k].e_rdata);
        end

        // ---------------- conflict sequence from reset ----------------
`ifdef MEM_ARB_RR_EN
        exp_grant = '{32'h100, 32'h40, 32'h100, 32'h40, 32'h100};
`else
        exp_grant = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h100};
`endif
        do_reset();
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        for (int g = 0; g < 5; g++) begin
            if (g == 4) d_req = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (m_req) found = 1'b1;
            end
            check($sformatf("conf%0d_grant_seen", g), 32'(found), 32'd1);
            check($sformatf("conf%0d_grant_addr", g), m_addr, exp_grant[g]);
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (i_valid || d_valid) found = 1'b1;
            end
            check($sformatf("conf%0d_valid_seen", g), 32'(found), 32'd1);
            check($sformatf("conf%0d_i_valid", g), 32'(i_valid), 32'(exp_grant[g] == 32'h100));
            check($sformatf("conf%0d_d_valid", g), 32'(d_valid), 32'(exp_grant[g] == 32'h40));
            @(posedge clk); #1;
        end
        drive_idle();

        // ---------------- reset in the middle of a load ----------------
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
        @(negedge clk);
        check("rst_mid_accept", 32'(m_req), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_d_valid_t1", 32'(d_valid), 32'd0);
        check("rst_mid_d_stall_t1", 32'(d_stall), 32'd0);
        check("rst_mid_m_req_t1",   32'(m_req),   32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check("rst_mid_d_valid_t2", 32'(d_valid), 32'd0);
        check("rst_mid_d_rdata_t2", d_rdata,      32'h0);
        check("rst_mid_outs_t2",
              {24'h0, m_req, m_we, i_valid, i_stall, d_valid, d_stall, 2'b00}, 32'h0);
        check("rst_mid_m_addr_t2",  m_addr | m_wdata | 32'(m_be) | i_rdata, 32'h0);

        // ---------------- LATENCY=3 fetch killed by flush ----------------
        @(posedge clk); #1;
        x_i_req = 1'b1; x_i_addr = 32'h180;                     // T
        @(negedge clk);
        check("kill_accept",      32'(x_m_req),  32'd1);
        check("kill_accept_addr", x_m_addr,      32'h180);
        @(posedge clk); #1;
        x_i_flush = 1'b1;                                       // T+1
        @(negedge clk);
        check("kill_t1_i_valid",  32'(x_i_valid), 32'd0);
        @(posedge clk); #1;
        x_i_flush = 1'b0; x_i_addr = 32'h200;                   // T+2
        @(negedge clk);
        check("kill_t2_m_req",    32'(x_m_req),   32'd0);
        @(posedge clk); #1;                                     // T+3
        @(negedge clk);
        check("kill_t3_i_valid",  32'(x_i_valid), 32'd0);
        check("kill_t3_i_stall",  32'(x_i_stall), 32'd1);
        check("kill_t3_m_req",    32'(x_m_req),   32'd0);
        @(posedge clk); #1;                                     // T+4: idle again
        @(negedge clk);
        check("kill_t4_m_req",    32'(x_m_req),   32'd1);
        check("kill_t4_m_addr",   x_m_addr,       32'h200);
        repeat (3) begin
            @(posedge clk); #1;
        end                                                     // T+7
        @(negedge clk);
        check("refetch_i_valid",  32'(x_i_valid), 32'd1);
        check("refetch_i_rdata",  x_i_rdata,      32'hA5A5_A5A5);
        check("refetch_no_d",     32'(x_d_valid | x_d_stall), 32'd0);
        @(posedge clk); #1;
        x_i_req = 1'b0;
        @(negedge clk);
        check("refetch_idle_stall", 32'(x_i_stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between instruction fetch and the load/store unit. Each requester holds a request until it receives a one-cycle valid pulse, and sees a combinational stall meanwhile. Memory has fixed read latency; the arbiter tracks one outstanding transaction, routes the response to its owner and discards fetch results killed by a taken branch.

## Interface
- LATENCY, 1, cycles from memory accept to m_rdata valid; legal ≥ 1
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- i_req  in  1  fetch request; held stable until i_valid
- i_addr  in  32  fetch address (word-aligned)
- i_flush  in  1  taken branch; kills fetch in flight or about to issue
- i_rdata  out  32  instruction word, meaningful when i_valid
- i_valid  out  1  one-cycle fetch completion pulse
- i_stall  out  1  i_req && !i_valid
- d_req  in  1  load/store request; held stable until d_valid
- d_we  in  1  1 = store
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  byte enables
- d_rdata  out  32  load data, meaningful when d_valid
- d_valid  out  1  one-cycle completion pulse (loads and stores)
- d_stall  out  1  d_req && !d_valid
- m_req  out  1  memory access strobe, one cycle per transaction
- m_we, m_addr, m_wdata, m_be  out  1/32/32/4  memory command; fetch drives we=0, be=4'hF
- m_rdata  in  32  memory read data, valid LATENCY cycles after m_req

## Operation
- FSM states S_IDLE, S_BUSY. Registers: state, owner, cnt, kill, last.
- S_IDLE: eligible fetch = i_req && !i_flush. If exactly one port is eligible, grant it. If both are eligible, arbitrate per Configuration. On grant: m_req=1 with the winner's command, owner := winner, cnt := 1, kill := 0, last := winner, go to S_BUSY. With no grant, m_req=0 and all m_* outputs are 0.
- S_BUSY: m_req=0. If cnt < LATENCY, cnt++.
- When cnt == LATENCY: the owner's valid = 1 and its rdata = m_rdata. This is suppressed for a fetch if kill or i_flush is set that cycle. Then go to S_IDLE.
- i_flush in S_BUSY with owner = I sets kill. The memory cycle completes but no i_valid is produced. i_flush has no effect on a data transaction.
- i_rdata and d_rdata pass m_rdata through; they are don't-care when the matching valid is low.
- A store's d_valid is produced at the same completion point as a load's.
- cnt width: $clog2(LATENCY+1).

## Timing
- Accept at cycle T. Valid pulse at T+LATENCY. Back in S_IDLE at T+LATENCY+1, when the next accept can occur. Throughput is 1 transaction per LATENCY+1 cycles.
- Reset values: state=S_IDLE, owner=I, cnt=0, kill=0, last=D. All outputs are 0 during reset and in the first idle cycle without requests.
- Reset mid-transaction abandons it: no valid pulse, and the memory response is ignored.
- Requesters see their stall high from the first request cycle through the cycle before valid. They must present their next request no earlier than the cycle after valid.
- i_flush in the same cycle as an idle fetch request: no fetch is issued, and a pending d_req may be granted.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on conflict. The port not equal to last wins. After reset, the first conflict goes to fetch.
- MEM_ARB_RR_EN undefined: fixed priority, data always wins a conflict. The last register is not built.

## Structure
- Shared package zep_mem_pkg holds:
  - owner_t enum {OWN_I, OWN_D}
  - arb_state_t enum {S_IDLE, S_BUSY}
  - constant BE_ALL = 4'hF
- Single module, no sub-module; the counter and FSM are too small to split.

## Test plan
- LATENCY=2: lone fetch i_addr=0x100 at T. Expect m_req=1 and m_addr=0x100 at T; i_valid=1 with i_rdata=mem[0x100] at T+2; i_stall high at T and T+1.
- LATENCY=2: store d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011. Expect m_we=1 and m_be=0011 at T, d_valid at T+2; a later load of 0x40 returns 0x0000BEEF (memory pre-zeroed).
- i_req and d_req together from reset:
  - MEM_ARB_RR_EN defined: grant order I, D, I, D.
  - MEM_ARB_RR_EN undefined: D is granted every time until d_req drops.
- LATENCY=3: fetch accepted at T, i_flush at T+1. Expect no i_valid at T+3, and S_IDLE at T+4.
- reset asserted at T+1 of a LATENCY=2 load. Expect no d_valid, state S_IDLE, all outputs 0 at T+2.
- i_flush together with i_req and d_req in S_IDLE. Expect the data port to be granted and no fetch m_req.
